// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
package axi_lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  // Latched request payload, held stable for the whole transaction
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  // AXI-Lite accesses are word aligned; the byte offset is carried by WSTRB
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Cycle counter that flags a bus phase which has lasted TIMEOUT_CYCLES cycles.
module axi_lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // expired is registered one cycle early so it is high during the last allowed cycle
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic            ARMED = 1'(TIMEOUT_CYCLES != 0);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_n;

  // Next count: clear wins, otherwise saturating increment while enabled
  always_comb begin
    count_n = count_q;
    if (clear) begin
      count_n = '0;
    end else if (enable && (count_q != '1)) begin
      count_n = count_q + TO_W'(1);
    end
  end

  // Counter and expiry flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      expired <= 1'b0;
    end else begin
      count_q <= count_n;
      expired <= ARMED && (count_n >= LIMIT);
    end
  end

endmodule

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator bridging a simple CPU req/resp bus.
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_arst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [STRB_W-1:0] M_AXI_WSTRB,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  input  logic [1:0]        M_AXI_BRESP,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP
);

  state_t            state_q, state_n;
  req_t              req_q, req_n;
  logic              awvalid_q, awvalid_n, wvalid_q, wvalid_n, arvalid_q, arvalid_n;
  logic              bready_q, bready_n, rready_q, rready_n;
  logic              req_ready_q, req_ready_n, resp_valid_q, resp_valid_n;
  logic              err_q, err_n, timeout_q, timeout_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              abort;
  logic              expired;
  logic              aw_hs_c, w_hs_c, wd_clear_c, wd_enable_c;

  assign aw_hs_c     = awvalid_q & M_AXI_AWREADY;
  assign w_hs_c      = wvalid_q & M_AXI_WREADY;
  assign wd_clear_c  = (state_n != state_q);
  assign wd_enable_c = (state_q == WR_ADDR) || (state_q == WR_RESP) ||
                       (state_q == RD_ADDR) || (state_q == RD_DATA);

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk    (axi_aclk),
    .rst    (axi_arst),
    .clear  (wd_clear_c),
    .enable (wd_enable_c),
    .expired(expired)
  );

  // Next-state and next-output decode; a handshake always beats the watchdog
  always_comb begin
    state_n      = state_q;
    req_n        = req_q;
    awvalid_n    = awvalid_q;
    wvalid_n     = wvalid_q;
    arvalid_n    = arvalid_q;
    bready_n     = bready_q;
    rready_n     = rready_q;
    req_ready_n  = req_ready_q;
    resp_valid_n = resp_valid_q;
    err_n        = err_q;
    timeout_n    = timeout_q;
    rdata_n      = rdata_q;
    abort        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_n.addr  = word_align(req_addr);
          req_n.wdata = req_wdata;
          req_n.wstrb = req_wstrb;
          req_ready_n = 1'b0;
          if (req_we) begin
            state_n   = WR_ADDR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_ADDR;
            arvalid_n = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (aw_hs_c) awvalid_n = 1'b0;
        if (w_hs_c)  wvalid_n  = 1'b0;
        if ((!awvalid_q || aw_hs_c) && (!wvalid_q || w_hs_c)) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end else if (expired && !aw_hs_c && !w_hs_c) begin
          abort = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_n      = RESP;
          bready_n     = 1'b0;
          resp_valid_n = 1'b1;
          err_n        = (M_AXI_BRESP != RESP_OKAY);
          timeout_n    = 1'b0;
          rdata_n      = '0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_n   = RD_DATA;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_n      = RESP;
          rready_n     = 1'b0;
          resp_valid_n = 1'b1;
          err_n        = (M_AXI_RRESP != RESP_OKAY);
          timeout_n    = 1'b0;
          rdata_n      = M_AXI_RDATA;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          req_ready_n  = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
      end
    endcase
    if (abort) begin
      state_n      = RESP;
      awvalid_n    = 1'b0;
      wvalid_n     = 1'b0;
      arvalid_n    = 1'b0;
      bready_n     = 1'b0;
      rready_n     = 1'b0;
      resp_valid_n = 1'b1;
      err_n        = 1'b1;
      timeout_n    = 1'b1;
      rdata_n      = '0;
    end
  end

  // State and output registers
  always_ff @(posedge axi_aclk or posedge axi_arst) begin
    if (axi_arst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_n;
      req_q        <= req_n;
      awvalid_q    <= awvalid_n;
      wvalid_q     <= wvalid_n;
      arvalid_q    <= arvalid_n;
      bready_q     <= bready_n;
      rready_q     <= rready_n;
      req_ready_q  <= req_ready_n;
      resp_valid_q <= resp_valid_n;
      err_q        <= err_n;
      timeout_q    <= timeout_n;
      rdata_q      <= rdata_n;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_timeout  = timeout_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = req_q.addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = req_q.wdata;
  assign M_AXI_WSTRB   = req_q.wstrb;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = req_q.addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed testbench for axi_lite_master_bridge with a configurable AXI-Lite slave.
module tb_axi_lite_master_bridge;

  localparam int unsigned TO = 8;

  logic        axi_aclk = 1'b0;
  logic        axi_arst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int total = 0;
  int bad = 0;

  // slave configuration, written only by the main sequence
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic        ar_never = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  // slave state and observations, written only by the slave process
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, b_fire = 1'b0, r_fire = 1'b0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, ar_unstable = 0;
  logic [31:0] seen_awaddr = '0, seen_wdata = '0, seen_araddr = '0, ar_first = '0;
  logic [3:0]  seen_wstrb = '0;

  always #5 axi_aclk = ~axi_aclk;

  axi_lite_master_bridge #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .axi_aclk(axi_aclk), .axi_arst(axi_arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  // Slave: decides READY/VALID mid-cycle for the coming rising edge
  always @(negedge axi_aclk) begin
    if (axi_arst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      if (aw_got && w_got) begin
        if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_cfg; end
        b_cnt++;
        if (bvalid && bready) begin b_hs++; b_fire = 1; aw_got = 0; w_got = 0; b_cnt = 0; end
      end
      if (ar_got) begin
        if (r_cnt >= r_delay) begin rvalid = 1; rresp = rresp_cfg; rdata = rdata_cfg; end
        r_cnt++;
        if (rvalid && rready) begin r_hs++; r_fire = 1; ar_got = 0; r_cnt = 0; end
      end
      if (awvalid) begin
        aw_hi++;
        awready = (aw_cnt >= aw_delay);
        aw_cnt++;
        if (awready) begin aw_hs++; aw_got = 1; aw_cnt = 0; seen_awaddr = awaddr; end
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        w_hi++;
        wready = (w_cnt >= w_delay);
        w_cnt++;
        if (wready) begin w_hs++; w_got = 1; w_cnt = 0; seen_wdata = wdata; seen_wstrb = wstrb; end
      end else begin wready = 0; w_cnt = 0; end
      if (arvalid) begin
        ar_hi++;
        if (ar_cnt == 0) ar_first = araddr;
        else if (araddr !== ar_first) ar_unstable++;
        arready = !ar_never && (ar_cnt >= ar_delay);
        ar_cnt++;
        if (arready) begin ar_hs++; ar_got = 1; ar_cnt = 0; seen_araddr = araddr; end
      end else begin arready = 0; ar_cnt = 0; end
    end
  end

  // Issue one request and collect its response; lat counts falling edges after acceptance
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic got, output logic [31:0] rd,
                        output logic err, output logic to, output int lat);
    got = 0; rd = '0; err = 0; to = 0; lat = 0;
    @(negedge axi_aclk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    @(posedge axi_aclk); #1;
    req_valid = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge axi_aclk);
      lat++;
      if (resp_valid) begin got = 1; break; end
    end
    if (got) begin
      rd = resp_rdata; err = resp_err; to = resp_timeout;
      resp_ready = 1;
      @(posedge axi_aclk); #1;
      resp_ready = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge axi_aclk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if ({awvalid, wvalid, arvalid, bready, rready, resp_valid} !== 6'b0) begin bad++;
      $display("FAIL rst_valid_ready got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, resp_valid}); end
    total++; if ({awaddr, wdata, wstrb, resp_rdata} !== 100'b0) begin bad++;
      $display("FAIL rst_payload got=%h want=0", {awaddr, wdata, wstrb, resp_rdata}); end
    total++; if ({resp_err, resp_timeout} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=00", {resp_err, resp_timeout}); end
    @(negedge axi_aclk); #1; axi_arst = 0;
    @(posedge axi_aclk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write_basic();
    logic got, err, to; logic [31:0] rd; int lat, b0;
    aw_delay = 1; w_delay = 1; b_delay = 0; bresp_cfg = 2'b00;
    b0 = b_hs;
    do_txn(1'b1, 32'h44, 32'h1, 4'hF, got, rd, err, to, lat);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL wr_resp_seen got=%b want=1", got); end
    total++; if (seen_awaddr !== 32'h44) begin bad++; $display("FAIL wr_awaddr got=%h want=00000044", seen_awaddr); end
    total++; if (seen_wdata !== 32'h1 || seen_wstrb !== 4'hF) begin bad++; $display("FAIL wr_wdata got=%h/%h want=00000001/f", seen_wdata, seen_wstrb); end
    total++; if (b_hs - b0 != 1) begin bad++; $display("FAIL wr_b_count got=%0d want=1", b_hs - b0); end
    total++; if ({err, to, rd} !== 34'b0) begin bad++; $display("FAIL wr_resp got err=%b to=%b rdata=%h want 0/0/0", err, to, rd); end
    total++; if (awprot !== 3'b000 || arprot !== 3'b000) begin bad++; $display("FAIL prot got=%b/%b want=000", awprot, arprot); end
  endtask

  task automatic test_read_basic();
    logic got, err, to; logic [31:0] rd; int lat, h0, u0;
    ar_delay = 2; r_delay = 3; rresp_cfg = 2'b00; rdata_cfg = 32'hDEAD_BEEF;
    h0 = ar_hi; u0 = ar_unstable;
    do_txn(1'b0, 32'h48, 32'h0, 4'h0, got, rd, err, to, lat);
    total++; if (got !== 1'b1 || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%b/%h want=1/deadbeef", got, rd); end
    total++; if (err !== 1'b0 || to !== 1'b0) begin bad++; $display("FAIL rd_err got=%b/%b want=0/0", err, to); end
    total++; if (seen_araddr !== 32'h48) begin bad++; $display("FAIL rd_araddr got=%h want=00000048", seen_araddr); end
    total++; if (ar_hi - h0 != 3 || ar_unstable != u0) begin bad++;
      $display("FAIL rd_arvalid_hold got cycles=%0d unstable=%0d want 3/0", ar_hi - h0, ar_unstable - u0); end
  endtask

  task automatic test_w_before_aw();
    logic got, err, to; logic [31:0] rd; int lat, b0, aw0, w0, awh0, wh0;
    aw_delay = 5; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    b0 = b_hs; aw0 = aw_hs; w0 = w_hs; awh0 = aw_hi; wh0 = w_hi;
    do_txn(1'b1, 32'h80, 32'h1234_5678, 4'h5, got, rd, err, to, lat);
    total++; if (w_hi - wh0 != 1) begin bad++; $display("FAIL wfirst_wvalid_cycles got=%0d want=1", w_hi - wh0); end
    total++; if (aw_hi - awh0 != 6) begin bad++; $display("FAIL wfirst_awvalid_cycles got=%0d want=6", aw_hi - awh0); end
    total++; if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin bad++;
      $display("FAIL wfirst_hs_counts got aw=%0d w=%0d b=%0d want 1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0); end
    total++; if (got !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL wfirst_resp got=%b/%b want=1/0", got, err); end
  endtask

  task automatic test_errors();
    logic got, err, to; logic [31:0] rd; int lat;
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
    rresp_cfg = 2'b11; rdata_cfg = 32'h1234_5678; bresp_cfg = 2'b10;
    do_txn(1'b0, 32'h50, 32'h0, 4'h0, got, rd, err, to, lat);
    total++; if ({got, err, to} !== 3'b110) begin bad++; $display("FAIL decerr_flags got=%b want=110", {got, err, to}); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL decerr_rdata got=%h want=12345678", rd); end
    do_txn(1'b1, 32'h54, 32'hFFFF_0000, 4'hC, got, rd, err, to, lat);
    total++; if ({got, err, to} !== 3'b110 || rd !== 32'h0) begin bad++;
      $display("FAIL slverr_resp got=%b rdata=%h want=110/0", {got, err, to}, rd); end
    rresp_cfg = 2'b00; bresp_cfg = 2'b00;
  endtask

  task automatic test_timeout();
    logic got, err, to; logic [31:0] rd; int lat, h0, a0;
    ar_never = 1; ar_delay = 0; r_delay = 0;
    h0 = ar_hi; a0 = ar_hs;
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, got, rd, err, to, lat);
    total++; if (ar_hi - h0 != 8 || ar_hs != a0) begin bad++;
      $display("FAIL to_arvalid got cycles=%0d hs=%0d want 8/0", ar_hi - h0, ar_hs - a0); end
    total++; if ({got, err, to} !== 3'b111 || rd !== 32'h0) begin bad++;
      $display("FAIL to_flags got=%b rdata=%h want=111/0", {got, err, to}, rd); end
    total++; if (lat != 9) begin bad++; $display("FAIL to_latency got=%0d want=9", lat); end
    ar_never = 0; rdata_cfg = 32'h0000_A5A5;
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, got, rd, err, to, lat);
    total++; if ({got, err, to} !== 3'b100 || rd !== 32'h0000_A5A5) begin bad++;
      $display("FAIL to_recover got=%b rdata=%h want=100/0000a5a5", {got, err, to}, rd); end
  endtask

  task automatic test_reset_mid();
    logic got, err, to; logic [31:0] rd; int lat;
    logic in_wr_resp;
    aw_delay = 0; w_delay = 0; b_delay = 6; in_wr_resp = 0;
    @(negedge axi_aclk);
    req_valid = 1; req_we = 1; req_addr = 32'h60; req_wdata = 32'h55; req_wstrb = 4'hF;
    @(posedge axi_aclk); #1;
    req_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge axi_aclk);
      if (bready) begin in_wr_resp = 1; break; end
    end
    total++; if (in_wr_resp !== 1'b1) begin bad++; $display("FAIL mid_reach_wr_resp got=%b want=1", in_wr_resp); end
    #1 axi_arst = 1;
    #1;
    total++; if ({awvalid, wvalid, arvalid, bready, rready, resp_valid} !== 6'b0) begin bad++;
      $display("FAIL mid_rst_outputs got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, resp_valid}); end
    total++; if (awaddr !== 32'h0 || wdata !== 32'h0) begin bad++; $display("FAIL mid_rst_payload got=%h/%h want=0/0", awaddr, wdata); end
    @(negedge axi_aclk); @(negedge axi_aclk); #1;
    axi_arst = 0; b_delay = 0; rdata_cfg = 32'h0BAD_F00D;
    @(posedge axi_aclk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_req_ready got=%b want=1", req_ready); end
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, got, rd, err, to, lat);
    total++; if ({got, err, to} !== 3'b100 || rd !== 32'h0BAD_F00D) begin bad++;
      $display("FAIL mid_next_read got=%b rdata=%h want=100/0badf00d", {got, err, to}, rd); end
  endtask

  task automatic test_back_to_back();
    logic got, err, to; logic [31:0] rd; int lat;
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0; rdata_cfg = 32'h1111_2222;
    do_txn(1'b0, 32'h4B, 32'h0, 4'h0, got, rd, err, to, lat);
    total++; if (lat != 3 || rd !== 32'h1111_2222) begin bad++; $display("FAIL b2b_read got lat=%0d rdata=%h want 3/11112222", lat, rd); end
    total++; if (seen_araddr !== 32'h48) begin bad++; $display("FAIL b2b_align got=%h want=00000048", seen_araddr); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", req_ready); end
    do_txn(1'b1, 32'h100, 32'hCAFE_F00D, 4'h3, got, rd, err, to, lat);
    total++; if (lat != 3 || {got, err, to} !== 3'b100) begin bad++; $display("FAIL b2b_write got lat=%0d flags=%b want 3/100", lat, {got, err, to}); end
    total++; if (seen_awaddr !== 32'h100 || seen_wdata !== 32'hCAFE_F00D || seen_wstrb !== 4'h3) begin bad++;
      $display("FAIL b2b_wpayload got=%h/%h/%h want=00000100/cafef00d/3", seen_awaddr, seen_wdata, seen_wstrb); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_w_before_aw();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
